block_ram_stream_reader: RTL and testbench
==========================================

# block_ram_stream_reader

Read-side controller for the team's dual-port block RAM. On a start command it walks a programmed address range, issues read strobes to the RAM read port, absorbs the RAM's one-cycle registered read latency in a 4-entry output buffer, and presents the words as an AXI-Stream master with `tlast` on the final word. It sits directly downstream of the RAM and runs in the RAM read clock domain.

## Interface
- `ADDR_WIDTH`, 1: width of RAM address; must match the RAM instance.
- `BYTE_WIDTH`, 1: RAM word width in bytes; data width is `BYTE_WIDTH*8`.
- `RAM_DEPTH`, 1: number of RAM words; address wrap point.

- `clk` in 1: single clock, same clock as the RAM read port.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `start_addr` in ADDR_WIDTH: first word address, sampled with `start`.
- `length` in ADDR_WIDTH+1: number of words to read, sampled with `start`; 0 is legal.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `ram_rd_en` out 1: RAM read strobe.
- `ram_rd_addr` out ADDR_WIDTH: RAM read address.
- `ram_rd_data` in BYTE_WIDTH*8: RAM registered read data.
- `m_axis_tdata` out BYTE_WIDTH*8: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: marks final word of transfer.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `start`=1 latches `start_addr`, `length`; `length`=0 -> DRAIN with zero words pending; else -> READ. `start` in READ/DRAIN is ignored.
- READ: issue `ram_rd_en`=1 with current address when `issue_left`>0 and `outstanding + fifo_count` < 4 (credit rule); each issue decrements `issue_left`, advances address. Address after `RAM_DEPTH-1` is 0 (non-power-of-two depth wraps exactly). Last issue -> DRAIN.
- RAM returns `ram_rd_data` valid the cycle after `ram_rd_en`; a registered copy of `ram_rd_en` (`rd_pending`) writes `ram_rd_data` into the buffer at that cycle's edge. Data is never taken from `ram_rd_data` in any other cycle (RAM holds stale data when not strobed).
- Buffer: 4-entry FIFO, `m_axis_tvalid` = FIFO not empty, `tdata` = head. Pop on `tvalid & tready`. Credit rule guarantees no overflow; overflow is a design error (assertion).
- `tlast` = 1 on the head entry iff it is the final word of the transfer (tracked by a word-out counter reaching `length`).
- DRAIN: exit when all issued words handshaken; next cycle `done`=1 for one cycle, state -> IDLE.
- `busy` = 1 in READ and DRAIN; 0 in IDLE including the `done` cycle.
- `tdata`/`tlast` stable while `tvalid`=1 and `tready`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_rd_en`=0, `ram_rd_addr`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0; FIFO empty, counters 0, state IDLE.
- `rst` mid-transfer: all above values next cycle; buffered and in-flight words discarded; no `done`.
- `start` at cycle T: `busy`=1 at T+1, first `ram_rd_en` at T+1, first `tvalid` at T+3.
- Round trip per buffer slot is 3 cycles; 4 entries sustain 1 word/cycle with `tready` held 1.
- `length`=N, `tready`=1 throughout: beats at T+3..T+N+2, `tlast` at T+N+2, `done` at T+N+3.
- `length`=0: `busy`=1 at T+1 only, `done`=1 at T+2, no beats, no `ram_rd_en`.
- `tready`=0: at most 4 reads issued ahead; `ram_rd_en` stalls until a pop frees credit.
- Simultaneous push and pop in one cycle: count unchanged, order preserved.

## Test plan
- RAM preloaded addr k = k; `start_addr`=2, `length`=5, `tready`=1 -> beats 2,3,4,5,6 on consecutive cycles, `tlast` on 6, `done` one cycle later.
- `RAM_DEPTH`=10, `start_addr`=8, `length`=4 -> addresses 8,9,0,1; data 8,9,0,1.
- `length`=16, `tready` toggled random 50% -> all 16 words in order, never more than 4 reads outstanding+buffered, data stable during stalls.
- `length`=0 -> `done` at T+2, `tvalid` and `ram_rd_en` never assert.
- `start` pulsed again while busy -> ignored, original transfer completes unchanged.
- `rst` asserted after 3 beats of `length`=8 -> all outputs reset next cycle; subsequent `start_addr`=0, `length`=2 yields clean beats 0,1 with `tlast` on 1.

Source files
------------

// File: rtl/block_ram_stream_reader.sv
// Walks a RAM address range, reads each word through the RAM's one-cycle
// registered read port, and streams the words out as an AXI-Stream master.
module block_ram_stream_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int BYTE_WIDTH = 1,
  parameter int RAM_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [ADDR_WIDTH:0]     length,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
  input  logic [BYTE_WIDTH*8-1:0] ram_rd_data,
  output logic [BYTE_WIDTH*8-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [1:0]              o_dbg_state
);

  // Stream handshake: a beat transfers on a rising edge where tvalid and
  // tready are both 1; tdata/tlast hold steady while tvalid=1 and tready=0.

  localparam int DW = BYTE_WIDTH * 8;
  localparam int LW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LW-1:0]         r_issue_left;
  logic [LW-1:0]         r_len;
  logic [LW-1:0]         r_out_cnt;
  logic                  r_rd_pending;
  logic                  r_done;
  logic [DW-1:0]         r_mem [4];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [2:0]            r_count;

  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_head_last;
  logic [2:0]            w_inflight;
  logic [LW-1:0]         w_out_next;

  // Credit counts words already requested from the RAM but not yet popped.
  assign w_inflight    = r_count + {2'b00, r_rd_pending};
  assign w_issue       = (r_state == S_READ) && (r_issue_left != '0) && (w_inflight < 3'd4);
  assign w_push        = r_rd_pending;
  assign m_axis_tvalid = (r_count != 3'd0);
  assign w_pop         = m_axis_tvalid && m_axis_tready;
  assign w_out_next    = r_out_cnt + LW'(1);
  assign w_head_last   = m_axis_tvalid && (w_out_next == r_len);

  assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;
  assign m_axis_tlast  = w_head_last;
  assign ram_rd_en     = w_issue;
  assign ram_rd_addr   = r_addr;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign o_dbg_state   = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (length == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        if (w_issue && (r_issue_left == LW'(1))) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((r_out_cnt == r_len) || (w_pop && w_head_last)) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_issue_left <= '0;
      r_len        <= '0;
      r_out_cnt    <= '0;
      r_rd_pending <= 1'b0;
      r_done       <= 1'b0;
      r_wr_ptr     <= 2'd0;
      r_rd_ptr     <= 2'd0;
      r_count      <= 3'd0;
    end else begin
      r_state      <= w_next;
      r_done       <= (r_state == S_DRAIN) && (w_next == S_IDLE);
      r_rd_pending <= w_issue;
      if ((r_state == S_IDLE) && start) begin
        r_addr       <= start_addr;
        r_issue_left <= length;
        r_len        <= length;
        r_out_cnt    <= '0;
      end
      // Wrap exactly at RAM_DEPTH so non-power-of-two depths work.
      if (w_issue) begin
        r_issue_left <= r_issue_left - LW'(1);
        r_addr       <= (r_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 2'd1;
        r_out_cnt <= w_out_next;
      end
      r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
    end
  end

  // Read data is only valid the cycle after a strobe; capture it only then.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= ram_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && (r_count == 3'd4)))
        else $error("output buffer overflow");
    end
  end

endmodule

// File: tb/tb_block_ram_stream_reader.sv
// Directed bench for block_ram_stream_reader with a RAM model and a beat
// scoreboard fed when each transfer is started.
module tb_block_ram_stream_reader;

  localparam int AW    = 4;
  localparam int BW    = 1;
  localparam int DEPTH = 10;
  localparam int DW    = BW * 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  block_ram_stream_reader #(
    .ADDR_WIDTH(AW),
    .BYTE_WIDTH(BW),
    .RAM_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .o_dbg_state  (dbg_state)
  );

  // RAM model: word k holds k; registered read, holds stale data when idle.
  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (ram_rd_en) ram_q <= ram[ram_rd_addr];
  end
  assign ram_rd_data = ram_q;

  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc_n = 0, t0 = 0;
  int first_valid, last_beat, done_cyc, done_cnt, beats;
  int n_valid = 0, n_rden = 0, issued = 0, popped = 0;
  int v0, r0;
  bit got_done;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (ram_rd_en) begin
      n_rden++;
      issued++;
      check("credit_bound", 32'(issued - popped <= 4), 1);
      if (exp_addr_q.size() > 0) check("rd_addr", 32'(ram_rd_addr), 32'(exp_addr_q.pop_front()));
      else check("extra_rd_en", 32'(ram_rd_en), 0);
    end
    if (prev_stall) begin
      check("stall_valid", 32'(m_axis_tvalid), 1);
      check("stall_data", 32'(m_axis_tdata), 32'(prev_data));
      check("stall_last", 32'(m_axis_tlast), 32'(prev_last));
    end
    if (m_axis_tvalid) begin
      n_valid++;
      if (first_valid < 0) first_valid = cyc_n;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      popped++;
      beats++;
      if (exp_q.size() == 0) begin
        check("extra_beat", 32'(m_axis_tvalid), 0);
      end else begin
        check("tdata", 32'(m_axis_tdata), 32'(exp_q.pop_front()));
        check("tlast", 32'(m_axis_tlast), 32'(exp_last_q.pop_front()));
      end
      if (m_axis_tlast) last_beat = cyc_n;
    end
    if (done) begin
      got_done = 1'b1;
      done_cnt++;
      done_cyc = cyc_n;
      check("done_busy", 32'(busy), 0);
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_last  = m_axis_tlast;
  endtask

  // Inputs change just after posedge; outputs are sampled at negedge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc_n++;
    #1;
  endtask

  task automatic start_xfer(input int addr, input int len);
    int a;
    a = addr;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(DW'(a));
      exp_last_q.push_back(i == len - 1);
      exp_addr_q.push_back(AW'(a));
      a = (a + 1) % DEPTH;
    end
    got_done    = 1'b0;
    done_cnt    = 0;
    first_valid = -1;
    last_beat   = -1;
    done_cyc    = -1;
    beats       = 0;
    t0          = cyc_n;
    start       = 1'b1;
    start_addr  = AW'(addr);
    length      = (AW+1)'(len);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    for (int i = 0; i < budget && !got_done; i++) begin
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
      cyc();
    end
    check("done_timeout", 32'(got_done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_rd_en"}, 32'(ram_rd_en), 0);
    check({tag, "_rd_addr"}, 32'(ram_rd_addr), 0);
    check({tag, "_tvalid"}, 32'(m_axis_tvalid), 0);
    check({tag, "_tlast"}, 32'(m_axis_tlast), 0);
    check({tag, "_tdata"}, 32'(m_axis_tdata), 0);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) ram[k] = DW'(k);
    rst           = 1'b1;
    start         = 1'b0;
    start_addr    = '0;
    length        = '0;
    m_axis_tready = 1'b1;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    cyc();

    // Basic transfer at full rate: 2..6, exact latency.
    start_xfer(2, 5);
    check("t1_busy_T1", 32'(busy), 1);
    check("t1_rden_T1", 32'(ram_rd_en), 1);
    wait_done(50, 1'b0);
    repeat (3) cyc();
    check("t1_first_valid", 32'(first_valid - t0), 3);
    check("t1_tlast_cyc", 32'(last_beat - t0), 7);
    check("t1_done_cyc", 32'(done_cyc - t0), 8);
    check("t1_beats", 32'(beats), 5);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // Address wrap at a non-power-of-two depth: 8,9,0,1.
    start_xfer(8, 4);
    wait_done(50, 1'b0);
    cyc();
    check("t2_done_cyc", 32'(done_cyc - t0), 7);
    check("t2_beats", 32'(beats), 4);
    check("t2_addr_q_empty", 32'(exp_addr_q.size()), 0);

    // Long transfer with random back-pressure.
    start_xfer(5, 16);
    wait_done(400, 1'b1);
    m_axis_tready = 1'b1;
    cyc();
    check("t3_beats", 32'(beats), 16);
    check("t3_q_empty", 32'(exp_q.size()), 0);

    // Zero length: done at T+2, no reads, no beats.
    v0 = n_valid;
    r0 = n_rden;
    start_xfer(3, 0);
    check("t4_busy_T1", 32'(busy), 1);
    check("t4_rden_T1", 32'(ram_rd_en), 0);
    wait_done(20, 1'b0);
    repeat (3) cyc();
    check("t4_done_cyc", 32'(done_cyc - t0), 2);
    check("t4_valid_cnt", 32'(n_valid - v0), 0);
    check("t4_rden_cnt", 32'(n_rden - r0), 0);
    check("t4_done_cnt", 32'(done_cnt), 1);

    // Start pulsed while busy is ignored.
    start_xfer(1, 6);
    cyc();
    start      = 1'b1;
    start_addr = AW'(0);
    length     = (AW+1)'(1);
    cyc();
    start = 1'b0;
    wait_done(50, 1'b0);
    repeat (4) cyc();
    check("t5_done_cyc", 32'(done_cyc - t0), 9);
    check("t5_beats", 32'(beats), 6);
    check("t5_done_cnt", 32'(done_cnt), 1);
    check("t5_q_empty", 32'(exp_q.size()), 0);
    check("t5_idle_tvalid", 32'(m_axis_tvalid), 0);

    // Reset mid-transfer after three beats, then a clean short transfer.
    start_xfer(0, 8);
    for (int i = 0; i < 50 && beats < 3; i++) cyc();
    check("t6_beats_before_rst", 32'(beats), 3);
    rst = 1'b1;
    cyc();
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    exp_addr_q.delete();
    issued     = 0;
    popped     = 0;
    prev_stall = 1'b0;
    got_done   = 1'b0;
    repeat (4) cyc();
    check("t6_no_done", 32'(got_done), 0);
    check("t6_no_tvalid", 32'(m_axis_tvalid), 0);
    start_xfer(0, 2);
    wait_done(50, 1'b0);
    cyc();
    check("t6_beats", 32'(beats), 2);
    check("t6_tlast_cyc", 32'(last_beat - t0), 4);
    check("t6_done_cyc", 32'(done_cyc - t0), 5);
    check("t6_q_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
